frame_pixel_source: RTL and testbench

Streams one raster frame out of a synchronous-read pixel memory and drives it, one byte per valid cycle, into the `ImageProcessing` input port. It is the transmit end of the pixel stream that the processing core consumes. It replaces file-driven stimulus with an on-chip source. Rows and frame boundaries are flagged so downstream blocks need no pixel counter of their own.

---
 rtl/frame_pixel_source_if.sv | 34 +++
 rtl/frame_pixel_source.sv | 155 +++++++++++++++
 tb/tb_frame_pixel_source.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_source_if.sv
// Bundles the pixel-memory read port, frame control and pixel output stream of frame_pixel_source.
// Latency: none, wires only.
// Backpressure: none here; the source block applies hold/abort to its own read issue.
interface frame_pixel_source_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
);
    logic              start;
    logic              abort;
    logic              hold;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              outputDataValid;
    logic [DATA_W-1:0] outputData;
    logic              line_end;
    logic              frame_end;
    logic              busy;
    logic              done;

    // The pixel source drives the memory read port and the pixel stream
    modport master (
        input  start, abort, hold, mem_rdata,
        output mem_rd, mem_addr, outputDataValid, outputData,
               line_end, frame_end, busy, done
    );

    // Environment side: control inputs, memory data, stream sink
    modport slave (
        output start, abort, hold, mem_rdata,
        input  mem_rd, mem_addr, outputDataValid, outputData,
               line_end, frame_end, busy, done
    );
endinterface

// File: rtl/frame_pixel_source.sv
// Streams one WIDTH x HEIGHT raster frame from a synchronous-read pixel memory, one pixel per valid cycle.
// Latency: read issued in cycle N appears on outputDataValid in cycle N+2; first read the cycle after start.
// Backpressure: hold suppresses new reads only (in-flight pixels still emit); abort discards everything in flight.
module frame_pixel_source #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_pixel_source_if.master  px
);
    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;

    logic              rd;
    logic              done;
    logic              x_last;
    logic              frame_last;

    // Tag pipeline: stage 1 lines up with mem_rdata, stage 2 is the output register
    logic              s1_vld_q, s1_eol_q, s1_last_q;
    logic              s2_vld_q, s2_eol_q, s2_last_q;
    logic [DATA_W-1:0] s2_dat_q;

    assign x_last     = (x_q == X_LAST);
    assign frame_last = x_last && (y_q == Y_LAST);

    // Next state, read issue and completion; abort wins over every other input
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        rd      = 1'b0;
        done    = 1'b0;
        if (px.abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (px.start) begin
                        state_d = S_RUN;
                        addr_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                S_RUN: begin
                    if (!px.hold) begin
                        rd     = 1'b1;
                        addr_d = addr_q + 1'b1;
                        if (x_last) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        if (frame_last) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final pixel is on the output this cycle: frame has left the block.
                    // A start here is taken immediately so back-to-back frames lose nothing.
                    if (s2_vld_q && s2_last_q) begin
                        done = 1'b1;
                        if (px.start) begin
                            state_d = S_RUN;
                            addr_d  = '0;
                            x_d     = '0;
                            y_d     = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state, read address and raster position registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Two-stage tag pipeline and output data register; abort empties both stages at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_eol_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_eol_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_dat_q  <= '0;
        end else if (px.abort) begin
            s1_vld_q  <= 1'b0;
            s1_eol_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_eol_q  <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            s1_vld_q  <= rd;
            s1_eol_q  <= rd && x_last;
            s1_last_q <= rd && frame_last;
            s2_vld_q  <= s1_vld_q;
            s2_eol_q  <= s1_eol_q;
            s2_last_q <= s1_last_q;
            // Data only advances with a real pixel so it holds across gaps
            if (s1_vld_q) begin
                s2_dat_q <= px.mem_rdata;
            end
        end
    end

    assign px.mem_rd          = rd;
    assign px.mem_addr        = addr_q;
    assign px.outputDataValid = s2_vld_q;
    assign px.outputData      = s2_dat_q;
    assign px.line_end        = s2_eol_q;
    assign px.frame_end       = s2_last_q;
    assign px.busy            = (state_q != S_IDLE);
    assign px.done            = done;
endmodule

// File: tb/tb_frame_pixel_source.sv
// Self-checking bench for frame_pixel_source on a 4x3 frame with a pixel-index reference model.
// Latency: model expects each read's pixel two cycles later, done with the last pixel.
// Backpressure: hold, start-while-busy, abort and async reset are driven from tables, sequences and random stimulus.
module tb_frame_pixel_source;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk;
    logic rst_n;

    frame_pixel_source_if #(.DATA_W(DW), .ADDR_W(AW)) px ();

    frame_pixel_source #(
        .WIDTH (W),
        .HEIGHT(H),
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .px (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read pixel memory
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (px.mem_rd) px.mem_rdata <= mem[int'(px.mem_addr)];
    end

    int errors = 0;
    int checks = 0;
    int pix_cnt = 0;
    int done_cnt = 0;
    logic obs_busy;

    // Reference model: frame phase (0 idle, 1 reading, 2 draining), next pixel index,
    // and the indices of the two reads in flight.
    int        m_st;
    int        m_next;
    bit        p1_v, p2_v;
    int        p1_i, p2_i;
    logic [DW-1:0] m_dat;

    task automatic model_reset();
        m_st = 0; m_next = 0;
        p1_v = 0; p2_v = 0; p1_i = 0; p2_i = 0;
        m_dat = '0;
    endtask

    function automatic bit e_rd();
        return (m_st == 1) && !px.hold && !px.abort && rst_n;
    endfunction

    function automatic bit e_done();
        return (m_st == 2) && p2_v && (p2_i == N - 1) && !px.abort;
    endfunction

    task automatic model_edge();
        bit rd, dn;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rd = e_rd();
        dn = e_done();
        if (px.abort) begin
            p1_v = 0; p2_v = 0;
        end else begin
            if (p1_v) begin
                p2_i  = p1_i;
                m_dat = mem[p1_i];
            end
            p2_v = p1_v;
            p1_v = rd;
            p1_i = m_next;
        end
        if (px.abort) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (px.start) begin m_st = 1; m_next = 0; end
        end else if (m_st == 1) begin
            if (rd) begin
                if (m_next == N - 1) m_st = 2;
                m_next++;
            end
        end else if (dn) begin
            if (px.start) begin m_st = 1; m_next = 0; end
            else m_st = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge
    task automatic step();
        @(negedge clk);
        chk("valid",     px.outputDataValid, p2_v);
        chk("data",      px.outputData, m_dat);
        chk("line_end",  px.line_end, p2_v && ((p2_i % W) == W - 1));
        chk("frame_end", px.frame_end, p2_v && (p2_i == N - 1));
        chk("busy",      px.busy, m_st != 0);
        chk("done",      px.done, e_done());
        chk("mem_rd",    px.mem_rd, e_rd());
        if (e_rd()) chk("mem_addr", px.mem_addr, m_next);
        if (px.outputDataValid === 1'b1) pix_cnt++;
        if (px.done === 1'b1) done_cnt++;
        obs_busy = px.busy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_to_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (m_st == 0 && !p1_v && !p2_v) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    endtask

    task automatic chk_all_low(input string nm);
        chk({nm, "_valid"}, px.outputDataValid, 0);
        chk({nm, "_data"},  px.outputData, 0);
        chk({nm, "_le"},    px.line_end, 0);
        chk({nm, "_fe"},    px.frame_end, 0);
        chk({nm, "_busy"},  px.busy, 0);
        chk({nm, "_done"},  px.done, 0);
        chk({nm, "_rd"},    px.mem_rd, 0);
        chk({nm, "_addr"},  px.mem_addr, 0);
    endtask

    typedef struct {
        int hold_at;     // reads issued before hold rises (-1: never)
        int hold_len;
        int restart_at;  // pixels seen when a stray start is pulsed (-1: never)
        int exp_pix;
        int exp_done;
        int exp_cyc;     // start cycle to first cycle with busy low
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   cyc, hcnt;
        bit   restarted, second;

        vecs[0] = '{-1, 0, -1, 12, 1, 15};
        vecs[1] = '{ 5, 2, -1, 12, 1, 17};
        vecs[2] = '{-1, 0,  6, 12, 1, 15};
        vecs[3] = '{ 0, 3, -1, 12, 1, 18};
        vecs[4] = '{11, 1, -1, 12, 1, 16};

        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        px.start = 0; px.abort = 0; px.hold = 0;
        rst_n = 0;
        model_reset();
        #3;
        chk_all_low("reset");
        step(); step();
        rst_n = 1;
        step();

        // Table-driven frames
        foreach (vecs[k]) begin
            pix_cnt = 0; done_cnt = 0; hcnt = 0; restarted = 0; cyc = 0;
            px.start = 1;
            step();
            px.start = 0;
            for (int c = 0; c < 200; c++) begin
                px.hold = (m_st == 1) && (m_next == vecs[k].hold_at) && (hcnt < vecs[k].hold_len);
                if (px.hold) hcnt++;
                px.start = (vecs[k].restart_at >= 0) && !restarted && (pix_cnt == vecs[k].restart_at);
                if (px.start) restarted = 1;
                step();
                cyc = c + 1;
                if (!obs_busy) break;
            end
            px.hold = 0; px.start = 0;
            step(); step();
            chk("vec_pixels", pix_cnt, vecs[k].exp_pix);
            chk("vec_dones",  done_cnt, vecs[k].exp_done);
            chk("vec_cycles", cyc, vecs[k].exp_cyc);
        end

        // Start in the done cycle launches a second frame without a gap
        pix_cnt = 0; done_cnt = 0; second = 0;
        px.start = 1;
        step();
        px.start = 0;
        for (int c = 0; c < 100; c++) begin
            px.start = e_done() && !second;
            if (px.start) second = 1;
            step();
            if (m_st == 0 && !p1_v && !p2_v) break;
        end
        px.start = 0;
        step();
        chk("b2b_pixels", pix_cnt, 2 * N);
        chk("b2b_dones",  done_cnt, 2);

        // Abort while pixel 7 is in flight and pixel 8 is about to be read
        pix_cnt = 0; done_cnt = 0;
        px.start = 1;
        step();
        px.start = 0;
        for (int c = 0; c < 50; c++) begin
            if (p1_v && p1_i == 7 && m_next == 8) break;
            step();
        end
        px.abort = 1;
        step();
        px.abort = 0;
        for (int c = 0; c < 5; c++) step();
        chk("abort_pixels", pix_cnt, 7);
        chk("abort_dones",  done_cnt, 0);
        chk("abort_busy",   obs_busy, 0);
        pix_cnt = 0;
        px.start = 1;
        step();
        px.start = 0;
        run_to_idle(100);
        chk("post_abort_pixels", pix_cnt, N);
        chk("post_abort_dones",  done_cnt, 1);

        // Asynchronous reset in the middle of pixel 5's cycle
        pix_cnt = 0; done_cnt = 0;
        px.start = 1;
        step();
        px.start = 0;
        for (int c = 0; c < 50 && pix_cnt < 5; c++) step();
        #2;
        rst_n = 0;
        #1;
        chk_all_low("async_rst");
        model_reset();
        step(); step();
        rst_n = 1;
        pix_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 5; c++) step();
        chk("post_rst_idle_pixels", pix_cnt, 0);
        px.start = 1;
        step();
        px.start = 0;
        run_to_idle(100);
        chk("post_rst_pixels", pix_cnt, N);
        chk("post_rst_dones",  done_cnt, 1);

        // Random control with fresh memory contents between frames
        for (int c = 0; c < 1500; c++) begin
            if (m_st == 0 && !p1_v && !p2_v && $urandom_range(0, 3) == 0)
                for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
            px.start = ($urandom_range(0, 7) == 0);
            px.hold  = ($urandom_range(0, 3) == 0);
            px.abort = ($urandom_range(0, 99) == 0);
            step();
        end
        px.start = 0; px.hold = 0; px.abort = 0;
        run_to_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
